// File: rtl/btb_fa.sv
// Fully-associative branch target buffer for the fetch stage.
//
// Holds (PC tag, target) pairs in 2**s_index entries. Fetch lookups get a
// registered response one cycle later. Execute allocates or updates an entry
// when a branch resolves taken. A tree pseudo-LRU picks the victim entry when
// all entries are valid.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   lookup_valid fetch presents lookup_pc this cycle
//   lookup_pc    fetch PC (bits [1:0] ignored)
//   resp_valid   registered: a lookup was presented last cycle
//   resp_hit     registered: last cycle's lookup matched a valid entry
//   resp_target  registered: predicted target, 0 on a miss
//   upd_valid    execute writes a resolved taken branch
//   upd_pc       branch PC (bits [1:0] ignored)
//   upd_target   resolved target
//   flush        synchronous invalidate of all entries
module btb_fa #(
  parameter int unsigned s_index   = 3,
  parameter int unsigned tag_width = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [31:0] resp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int unsigned Entries = 1 << s_index;
  localparam int unsigned Nodes   = Entries - 1;

  logic [Entries-1:0]   valid_q, valid_d;
  logic [Nodes-1:0]     plru_q, plru_d;
  logic [tag_width-1:0] tag_q    [Entries];
  logic [31:0]          target_q [Entries];

  logic                 resp_valid_q, resp_hit_q;
  logic [31:0]          resp_target_q;

  logic [tag_width-1:0] lk_tag, up_tag;
  logic                 lk_hit, up_hit, free_any, do_write;
  logic [s_index-1:0]   lk_idx, up_idx, free_idx, victim_idx, wr_idx;
  logic [31:0]          lk_target;

  logic                 unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_tag = lookup_pc[2 +: tag_width];
  assign up_tag = upd_pc[2 +: tag_width];

  // Lookup match; the update rule keeps tags unique so the OR-mux is one-hot.
  always_comb begin
    lk_hit    = 1'b0;
    lk_idx    = '0;
    lk_target = '0;
    for (int i = 0; i < int'(Entries); i++) begin
      if (valid_q[i] && tag_q[i] == lk_tag) begin
        lk_hit    = 1'b1;
        lk_idx    = i[s_index-1:0];
        lk_target = lk_target | target_q[i];
      end
    end
  end

  // Update tag match and lowest-numbered invalid entry.
  always_comb begin
    up_hit   = 1'b0;
    up_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < int'(Entries); i++) begin
      if (valid_q[i] && tag_q[i] == up_tag) begin
        up_hit = 1'b1;
        up_idx = i[s_index-1:0];
      end
    end
    // Descending scan so the lowest invalid index wins.
    for (int i = int'(Entries) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = i[s_index-1:0];
      end
    end
  end

  // Victim walk: node bit at depth d is index bit d (LSB at the root).
  always_comb begin : victim_walk
    int node;
    logic b;
    node       = 0;
    victim_idx = '0;
    for (int d = 0; d < int'(s_index); d++) begin
      b             = plru_q[node];
      victim_idx[d] = b;
      node          = 2 * node + 1 + int'(b);
    end
  end

  assign do_write = upd_valid & ~flush;
  assign wr_idx   = up_hit ? up_idx : (free_any ? free_idx : victim_idx);

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (do_write) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // At most one touch per cycle: update wins over a lookup hit. Flush leaves
  // the tree untouched.
  always_comb begin : plru_touch
    int node;
    logic               touch_en;
    logic [s_index-1:0] touch_idx;
    plru_d    = plru_q;
    touch_en  = 1'b0;
    touch_idx = '0;
    node      = 0;
    if (!flush) begin
      if (do_write) begin
        touch_en  = 1'b1;
        touch_idx = wr_idx;
      end else if (lookup_valid && lk_hit) begin
        touch_en  = 1'b1;
        touch_idx = lk_idx;
      end
    end
    if (touch_en) begin
      for (int d = 0; d < int'(s_index); d++) begin
        plru_d[node] = ~touch_idx[d];
        node         = 2 * node + 1 + int'(touch_idx[d]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      plru_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      plru_q        <= plru_d;
      resp_valid_q  <= lookup_valid;
      resp_hit_q    <= lookup_valid & lk_hit;
      resp_target_q <= (lookup_valid && lk_hit) ? lk_target : 32'h0;
    end
  end

  // Payload arrays are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_q[wr_idx]    <= up_tag;
      target_q[wr_idx] <= upd_target;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_target = resp_target_q;

endmodule

// File: tb/tb_btb_fa.sv
// Directed self-checking bench for btb_fa with 4 entries.
module tb_btb_fa;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        flush;

  int checks;
  int errors;

  btb_fa #(
    .s_index  (2),
    .tag_width(30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_valid(lookup_valid),
    .lookup_pc   (lookup_pc),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_target (resp_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, sample 1 time unit later, then idle.
  task automatic cyc(input logic lv, input logic [31:0] lpc, input logic uv,
                     input logic [31:0] upc, input logic [31:0] utgt, input logic fl);
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_target   = utgt;
    flush        = fl;
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== 34'h0) begin
      errors++;
      $display("FAIL reset_resp got v=%0b h=%0b t=%h want 0/0/0", resp_valid, resp_hit,
               resp_target);
    end
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_first_lookup got v=%0b h=%0b t=%h want 1/0/0", resp_valid,
               resp_hit, resp_target);
    end
  endtask

  task automatic test_hit();
    apply_reset();
    cyc(1'b0, 32'h0, 1'b1, 32'h100, 32'h200, 1'b0);
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL hit_100 got v=%0b h=%0b t=%h want 1/1/200", resp_valid, resp_hit,
               resp_target);
    end
    cyc(1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL miss_104 got v=%0b h=%0b t=%h want 1/0/0", resp_valid, resp_hit,
               resp_target);
    end
    // Low PC bits are not part of the tag.
    cyc(1'b1, 32'h103, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL hit_103 got v=%0b h=%0b t=%h want 1/1/200", resp_valid, resp_hit,
               resp_target);
    end
    cyc(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== 34'h0) begin
      errors++;
      $display("FAIL no_lookup got v=%0b h=%0b t=%h want 0/0/0", resp_valid, resp_hit,
               resp_target);
    end
  endtask

  // Fill entries 0..3 with pc 0x100,0x110,0x120,0x130 -> target 0x1000+pc.
  task automatic fill4();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i * 16), 32'h1100 + 32'(i * 16), 1'b0);
    end
  endtask

  task automatic test_plru();
    logic [31:0] pcs [5];
    logic        exp_hit [5];
    pcs     = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h140};
    exp_hit = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    fill4();
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h1100}) begin
      errors++;
      $display("FAIL plru_touch_hit got h=%0b t=%h want 1/1100", resp_hit, resp_target);
    end
    // Touches 0,1,2,3,0 leave node0=1, node2=0: victim index bits {0,1} = entry 1.
    // The same-cycle lookup of that victim still returns its old target.
    cyc(1'b1, 32'h110, 1'b1, 32'h140, 32'h1140, 1'b0);
    checks++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h1110}) begin
      errors++;
      $display("FAIL victim_read_old got h=%0b t=%h want 1/1110", resp_hit, resp_target);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, pcs[i], 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if ({resp_hit, resp_target} !== {exp_hit[i], exp_hit[i] ? pcs[i] + 32'h1000 : 32'h0})
      begin
        errors++;
        $display("FAIL after_evict pc=%h got h=%0b t=%h want h=%0b", pcs[i], resp_hit,
                 resp_target, exp_hit[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cyc(1'b0, 32'h0, 1'b1, 32'h100, 32'h200, 1'b0);
    cyc(1'b1, 32'h100, 1'b1, 32'h100, 32'h300, 1'b0);
    checks++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL same_cycle_old got h=%0b t=%h want 1/200", resp_hit, resp_target);
    end
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL same_cycle_new got h=%0b t=%h want 1/300", resp_hit, resp_target);
    end
    // Three more allocations must fit without evicting anything.
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i * 16), 32'h1100 + 32'(i * 16), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h100 + 32'(i * 16), 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if ({resp_hit, resp_target} !== {1'b1, (i == 0) ? 32'h300 : 32'h1100 + 32'(i * 16)})
      begin
        errors++;
        $display("FAIL no_duplicate idx=%0d got h=%0b t=%h", i, resp_hit, resp_target);
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    fill4();
    cyc(1'b1, 32'h120, 1'b1, 32'h500, 32'h600, 1'b1);
    checks++;
    if ({resp_hit, resp_target} !== {1'b1, 32'h1120}) begin
      errors++;
      $display("FAIL flush_prestate got h=%0b t=%h want 1/1120", resp_hit, resp_target);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i == 4) ? 32'h500 : 32'h100 + 32'(i * 16), 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL flush_miss idx=%0d got v=%0b h=%0b t=%h want 1/0/0", i, resp_valid,
                 resp_hit, resp_target);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cyc(1'b0, 32'h0, 1'b1, 32'h100, 32'h200, 1'b0);
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL pre_async got v=%0b h=%0b t=%h want 1/1/200", resp_valid, resp_hit,
               resp_target);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== 34'h0) begin
      errors++;
      $display("FAIL async_clear got v=%0b h=%0b t=%h want 0/0/0", resp_valid, resp_hit,
               resp_target);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({resp_valid, resp_hit, resp_target} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL post_async got v=%0b h=%0b t=%h want 1/0/0", resp_valid, resp_hit,
               resp_target);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_target   = '0;
    flush        = 1'b0;
    #3;
    test_reset();
    test_hit();
    test_plru();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
